// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter using the shift-and-add-3 (double dabble) method.
// One operand bit is shifted into the BCD scratch register per clock. A conversion
// takes WIDTH shift cycles plus one DONE cycle.
// Optional build macro: BCD_SIGNED_EN. When it is defined, bin is treated as two's
// complement, its magnitude is converted and neg carries the sign. When it is not
// defined, bin is unsigned and neg is tied low.
module bin2bcd_seq #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  neg
);

    localparam int unsigned BcdW = 4 * DIGITS;
    localparam int unsigned CntW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  operand_q, operand_d;
    logic [BcdW-1:0]   scratch_q, scratch_d;
    logic [BcdW-1:0]   scratch_adj;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [BcdW-1:0]   bcd_q, bcd_d;
    logic              done_q, done_d;
    logic [WIDTH-1:0]  bin_mag;

`ifdef BCD_SIGNED_EN
    logic              bin_neg;
    logic              sign_q, sign_d;
    logic              neg_q, neg_d;

    // Magnitude of the two's complement input. The most negative value wraps back to
    // itself, which read as unsigned is exactly 2^(WIDTH-1).
    always_comb begin
        bin_neg = bin[WIDTH-1];
        bin_mag = bin_neg ? (~bin + WIDTH'(1)) : bin;
    end
`else
    // Unsigned build: the operand is taken as is.
    always_comb begin
        bin_mag = bin;
    end
`endif

    // Add 3 to every scratch digit that is 5 or more, so that the following shift
    // carries correctly into the next decimal digit.
    always_comb begin
        scratch_adj = scratch_q;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (scratch_q[4*i +: 4] >= 4'd5) begin
                scratch_adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // Next-state logic for the FSM and its datapath registers.
    always_comb begin
        state_d   = state_q;
        operand_d = operand_q;
        scratch_d = scratch_q;
        cnt_d     = cnt_q;
        bcd_d     = bcd_q;
        done_d    = 1'b0;
`ifdef BCD_SIGNED_EN
        sign_d    = sign_q;
        neg_d     = neg_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    operand_d = bin_mag;
                    scratch_d = '0;
                    cnt_d     = CntW'(WIDTH);
`ifdef BCD_SIGNED_EN
                    sign_d    = bin_neg;
`endif
                    state_d   = StShift;
                end
            end
            StShift: begin
                // Shift {scratch, operand} left by one. The top bit of the adjusted
                // scratch is always zero because 10^DIGITS > 2^WIDTH - 1.
                scratch_d = {scratch_adj[BcdW-2:0], operand_q[WIDTH-1]};
                operand_d = {operand_q[WIDTH-2:0], 1'b0};
                cnt_d     = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                bcd_d   = scratch_q;
                done_d  = 1'b1;
`ifdef BCD_SIGNED_EN
                neg_d   = sign_q;
`endif
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State register. Reset is synchronous and has priority over start.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            operand_q <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            bcd_q     <= '0;
            done_q    <= 1'b0;
`ifdef BCD_SIGNED_EN
            sign_q    <= 1'b0;
            neg_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            operand_q <= operand_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            bcd_q     <= bcd_d;
            done_q    <= done_d;
`ifdef BCD_SIGNED_EN
            sign_q    <= sign_d;
            neg_q     <= neg_d;
`endif
        end
    end

    // Output assignments.
    assign busy = (state_q != StIdle);
    assign done = done_q;
    assign bcd  = bcd_q;
`ifdef BCD_SIGNED_EN
    assign neg  = neg_q;
`else
    assign neg  = 1'b0;
`endif

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Randomised self-checking bench for bin2bcd_seq (WIDTH=16, DIGITS=5).
// Expected results come from a decimal reference model that uses / and %.
module tb_bin2bcd_seq;

    localparam int unsigned WIDTH  = 16;
    localparam int unsigned DIGITS = 5;
    localparam int          LAT    = WIDTH + 1;  // edges from acceptance to done

    logic                clk;
    logic                rst;
    logic                start;
    logic [WIDTH-1:0]    bin;
    logic                busy;
    logic                done;
    logic [4*DIGITS-1:0] bcd;
    logic                neg;

    int chk_cnt;
    int pass_cnt;

    bin2bcd_seq #(
        .WIDTH  (WIDTH),
        .DIGITS (DIGITS)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .bcd   (bcd),
        .neg   (neg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Converted magnitude as an integer, following the build's signedness.
    function automatic int unsigned ref_mag(input logic [WIDTH-1:0] v);
        int unsigned m;
        m = int'(v);
`ifdef BCD_SIGNED_EN
        if (v[WIDTH-1]) m = (1 << WIDTH) - int'(v);
`endif
        return m;
    endfunction

    function automatic logic [4*DIGITS-1:0] ref_bcd(input logic [WIDTH-1:0] v);
        int unsigned m;
        logic [4*DIGITS-1:0] r;
        m = ref_mag(v);
        r = '0;
        for (int d = 0; d < int'(DIGITS); d++) begin
            r[4*d +: 4] = 4'(m % 10);
            m = m / 10;
        end
        return r;
    endfunction

    function automatic logic ref_neg(input logic [WIDTH-1:0] v);
`ifdef BCD_SIGNED_EN
        return v[WIDTH-1];
`else
        return (v != v);
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // A single conversion: checks latency, busy length, result, sign, that bcd holds
    // during the shift phase, and that done is a one-cycle pulse.
    task automatic run_conv(input logic [WIDTH-1:0] v, input string tag);
        logic [4*DIGITS-1:0] held;
        logic hold_ok;
        int n;
        int bcount;
        bin   = v;
        start = 1'b1;
        step();
        start  = 1'b0;
        bin    = WIDTH'($urandom);   // must not disturb the conversion in progress
        held   = bcd;
        hold_ok = 1'b1;
        bcount = busy ? 1 : 0;
        n      = 0;
        while (!done && n < 40) begin
            step();
            n++;
            if (busy) bcount++;
            if (!done && bcd !== held) hold_ok = 1'b0;
        end
        check_eq({tag, "_latency"}, 32'(n), 32'(LAT));
        check_eq({tag, "_busy_len"}, 32'(bcount), 32'(LAT));
        check_eq({tag, "_bcd"}, 32'(bcd), 32'(ref_bcd(v)));
        check_eq({tag, "_neg"}, 32'(neg), 32'(ref_neg(v)));
        check_eq({tag, "_bcd_hold"}, 32'(hold_ok), 32'd1);
        step();
        check_eq({tag, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        int dcnt;
        int last;
        logic [4*DIGITS-1:0] seen;
        chk_cnt  = 0;
        pass_cnt = 0;
        rst   = 1'b1;
        start = 1'b1;   // reset must win over start
        bin   = 16'd500;
        step();
        step();
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_bcd", 32'(bcd), 32'd0);
        check_eq("rst_neg", 32'(neg), 32'd0);
        rst   = 1'b0;
        start = 1'b0;
        step();

        run_conv(16'd0, "zero");
`ifdef BCD_SIGNED_EN
        run_conv(16'hFFFF, "minus1");
        run_conv(16'h8000, "most_neg");
        run_conv(16'h7FFF, "most_pos");
`else
        run_conv(16'd65535, "all_ones");
        run_conv(16'd12345, "v12345");
        run_conv(16'd100, "v100");
`endif
        for (int i = 0; i < 20; i++) begin
            run_conv(WIDTH'($urandom), "rand");
        end

        // Start while busy is ignored and the original operand is converted.
        bin   = 16'd1234;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (4) step();
        bin   = 16'd4321;
        start = 1'b1;
        step();
        start = 1'b0;
        dcnt  = 0;
        seen  = '0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (done) begin
                dcnt++;
                seen = bcd;
            end
        end
        check_eq("busy_start_pulses", 32'(dcnt), 32'd1);
        check_eq("busy_start_bcd", 32'(seen), 32'(ref_bcd(16'd1234)));

        // Reset during the shift phase aborts the conversion without a done pulse.
        bin   = 16'd777;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (7) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("abort_busy", 32'(busy), 32'd0);
        check_eq("abort_bcd", 32'(bcd), 32'd0);
        check_eq("abort_done", 32'(done), 32'd0);
        dcnt = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (done) dcnt++;
        end
        check_eq("abort_no_done", 32'(dcnt), 32'd0);
        run_conv(16'd9876, "after_abort");

        // Continuous start: a new conversion every WIDTH+2 cycles.
        bin   = 16'd42;
        start = 1'b1;
        dcnt  = 0;
        last  = -1;
        for (int i = 1; i <= 60; i++) begin
            step();
            if (done) begin
                dcnt++;
                check_eq("cont_bcd", 32'(bcd), 32'(ref_bcd(16'd42)));
                if (last >= 0) check_eq("cont_period", 32'(i - last), 32'(WIDTH + 2));
                last = i;
            end
        end
        start = 1'b0;
        check_eq("cont_pulses", 32'(dcnt), 32'd3);
        repeat (20) step();

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/bin2bcd_seq.md
BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

Interface
REQ-001 Parameter WIDTH, default 16: binary input width; the number of shift iterations equals WIDTH.
REQ-002 Parameter DIGITS, default 5: number of BCD output digits; DIGITS SHALL satisfy 10^DIGITS > 2^WIDTH - 1.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  conversion request, sampled each rising edge.
REQ-006 bin  input  WIDTH  binary value to convert (e.g. the ALU result); sampled only when start is accepted.
REQ-007 busy  output  1  high while a conversion is in progress, i.e. in SHIFT or DONE.
REQ-008 done  output  1  single-cycle completion pulse.
REQ-009 bcd  output  4*DIGITS  packed BCD result, units in [3:0], most significant digit in the top nibble; feeds the display multiplexer.
REQ-010 neg  output  1  sign of the converted value (see Configuration).

Function
REQ-011 The block SHALL implement an FSM with states IDLE, SHIFT and DONE.
REQ-012 IDLE: when start=1, the block SHALL latch bin (or its magnitude), clear the BCD scratch register, load the iteration counter with WIDTH and go to SHIFT; otherwise it stays in IDLE.
REQ-013 SHIFT, each cycle: every scratch digit >= 5 SHALL first get +3, then {scratch, operand} SHALL shift left by one, with the operand MSB entering scratch bit 0; the counter then decrements.
REQ-014 After the WIDTH-th SHIFT cycle the FSM SHALL go to DONE.
REQ-015 DONE lasts exactly one cycle: bcd (and neg) are loaded from scratch, done=1, and the next state is IDLE.
REQ-016 Latency: with start accepted at edge k, done SHALL be high in the cycle after edge k+WIDTH+1 (edge 17 for WIDTH=16); throughput is one conversion per WIDTH+2 cycles.
REQ-017 bcd and neg SHALL hold the last completed result and SHALL NOT change during SHIFT.
REQ-018 start while busy=1 (SHIFT or DONE) SHALL be ignored; there is no queuing.
REQ-019 start held high continuously SHALL start a new conversion on each return to IDLE.
REQ-020 bin changing after acceptance SHALL NOT affect the conversion in progress.
REQ-021 Every digit of bcd SHALL be in the range 0..9 for all inputs; the all-ones input SHALL convert exactly.

Reset
REQ-022 rst=1 at a rising edge SHALL force state=IDLE, counter=0, scratch=0, bcd=0, neg=0, done=0 and busy=0.
REQ-023 rst SHALL take priority over start, and rst during SHIFT SHALL abort the conversion with no done pulse.

Configuration
REQ-024 Macro BCD_SIGNED_EN SHALL select whether signed conversion is compiled in.
REQ-025 With BCD_SIGNED_EN defined, bin is two's complement: the block SHALL convert its magnitude (-bin if bin[WIDTH-1]=1) and load neg with bin[WIDTH-1] in DONE.
REQ-026 With BCD_SIGNED_EN defined, the most negative input SHALL convert to magnitude 2^(WIDTH-1).
REQ-027 Without BCD_SIGNED_EN, bin is unsigned and neg SHALL be tied to 0, keeping the port list identical in both builds.

Verification
REQ-028 Reset, then start=1 with bin=0 for one cycle -> busy high for 17 cycles, done pulse at edge 17, bcd=20'h00000.
REQ-029 Unsigned build, bin=65535 -> bcd=20'h65535; bin=12345 -> bcd=20'h12345; bin=100 -> bcd=20'h00100.
REQ-030 start pulsed at edge 5 of a conversion, with bin changed -> ignored; exactly one done pulse, carrying the original result.
REQ-031 rst asserted at SHIFT cycle 8 -> no done pulse, bcd=0, busy=0 on the next cycle; a new start then completes normally.
REQ-032 Signed build: bin=16'hFFFF -> neg=1, bcd=20'h00001; bin=16'h8000 -> neg=1, bcd=20'h32768; bin=16'h7FFF -> neg=0, bcd=20'h32767.
REQ-033 start held high for 60 cycles with bin=42 -> done pulses every 18 cycles, each with bcd=20'h00042.
